instr_loader: RTL and testbench

//  Writer side of the instruction-memory read path: receives a program as a byte

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_loader_byte_packer.sv | 44 ++++
 rtl/instr_loader.sv | 109 ++++++++++
 tb/tb_instr_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the instruction loader: state encoding and
// the default memory geometry.
package instr_loader_pkg;

    localparam int LDR_ADDR_W = 8;
    localparam int LDR_DATA_W = 32;
    localparam int LDR_DEPTH  = 256;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles little-endian bytes into DATA_W words; word_valid flags the cycle
// the final byte of a word is accepted, with that byte already merged into word.
module instr_loader_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic [BW-1:0]     byte_idx;
    logic [DATA_W-1:0] assemble;
    logic              last;

    assign last = (byte_idx == BW'(NB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            assemble <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (accept) begin
            assemble[byte_idx*8 +: 8] <= in_data;
            byte_idx                  <= last ? '0 : byte_idx + 1'b1;
        end
    end

    // Every byte lane is rewritten per word, so stale lanes never leak out.
    always_comb begin
        word                  = assemble;
        word[byte_idx*8 +: 8] = in_data;
    end

    assign word_valid = accept & last;

endmodule

// File: rtl/instr_loader.sv
// Loads a program image from a byte stream into instruction memory and holds
// the CPU in reset until a complete image has been written.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DATA_W = LDR_DATA_W,
    parameter int DEPTH  = LDR_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] checksum
);

    ldr_state_t        state, state_next;
    logic [ADDR_W:0]   len_sat, len_reg;
    logic [ADDR_W-1:0] word_cnt;
    logic [DATA_W-1:0] acc, word;
    logic              accept, word_valid, last_word, take_start;

    // Saturating len keeps word_cnt, and thus mem_addr, below DEPTH.
    assign len_sat    = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
    assign take_start = (state == LDR_IDLE) && start && !abort;
    assign accept     = in_valid && in_ready;
    assign last_word  = ({1'b0, word_cnt} == len_reg - 1'b1);

    instr_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (take_start | abort),
        .accept     (accept),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LDR_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = LDR_IDLE;
        end else begin
            case (state)
                LDR_IDLE: if (start) state_next = (len_sat == '0) ? LDR_DONE : LDR_LOAD;
                LDR_LOAD: if (word_valid && last_word) state_next = LDR_DONE;
                LDR_DONE: state_next = LDR_IDLE;
                default:  state_next = LDR_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == LDR_LOAD) && !abort;
        busy     = (state == LDR_LOAD);
        done     = (state == LDR_DONE) && !abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg   <= '0;
            word_cnt  <= '0;
            acc       <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            checksum  <= '0;
            cpu_hold  <= 1'b1;
        end else begin
            mem_write <= 1'b0;
            if (abort) begin
                cpu_hold <= 1'b1;
            end else if (take_start) begin
                len_reg  <= len_sat;
                word_cnt <= '0;
                acc      <= '0;
                cpu_hold <= 1'b1;
            end else begin
                if (word_valid) begin
                    mem_write <= 1'b1;
                    mem_addr  <= word_cnt;
                    mem_data  <= word;
                    acc       <= acc ^ word;
                    if (!last_word) word_cnt <= word_cnt + 1'b1;
                end
                if (done) begin
                    checksum <= acc;
                    cpu_hold <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a word-level model
// of the image load (expected writes, checksum, done count, cpu_hold).
module tb_instr_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic [DATA_W-1:0] checksum;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_e;
    logic [7:0]               pld[$];
    logic [ADDR_W-1:0]        last_addr;
    logic [DATA_W-1:0]        chk_exp;
    logic                     hold_exp;

    instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .cpu_hold  (cpu_hold),
        .checksum  (checksum)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && mem_write) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", mem_write, 1'b0);
            end else begin
                exp_e = exp_q.pop_front();
                check("write", {mem_addr, mem_data}, exp_e);
                last_addr = mem_addr;
            end
        end
        if (done) done_cnt++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pld.delete();
        for (int i = 0; i < n; i++) pld.push_back(8'($urandom_range(255, 0)));
    endtask

    // Model: full words sent become writes; checksum is XOR of them only when
    // the load completes; an abort leaves checksum alone and holds the CPU.
    task automatic run_load(input int n_len, input int gap_max, input int abort_at,
                            input int mid_start_at);
        int                eff, nb, full_words, d0, exp_done;
        logic [DATA_W-1:0] w, acc;
        eff        = (n_len > DEPTH) ? DEPTH : n_len;
        nb         = eff * 4;
        full_words = (abort_at >= 0) ? abort_at / 4 : eff;
        acc        = '0;
        for (int i = 0; i < full_words; i++) begin
            w = {pld[4*i+3], pld[4*i+2], pld[4*i+1], pld[4*i]};
            exp_q.push_back({ADDR_W'(i), w});
            acc ^= w;
        end
        if (abort_at < 0) begin
            chk_exp  = acc;
            hold_exp = 1'b0;
            exp_done = 1;
        end else begin
            hold_exp = 1'b1;
            exp_done = 0;
        end
        d0    = done_cnt;
        start = 1'b1;
        len   = (ADDR_W+1)'(n_len);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, (eff > 0) ? 1'b1 : 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (abort_at == i) break;
            if (mid_start_at == i) begin
                start = 1'b1;
                len   = (ADDR_W+1)'(3);
                tick();
                start = 1'b0;
            end
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            send_byte(pld[i]);
        end
        if (abort_at >= 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        repeat (3) tick();
        check("done_pulses", done_cnt - d0, exp_done);
        check("checksum", checksum, chk_exp);
        check("cpu_hold", cpu_hold, hold_exp);
        check("busy_idle", busy, 1'b0);
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int nl, ab;
        rst      = 1'b0;
        start    = 1'b0;
        len      = '0;
        abort    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        chk_exp  = '0;
        hold_exp = 1'b1;
        last_addr = '0;

        repeat (2) @(negedge clk);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_checksum", checksum, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("idle_cpu_hold", cpu_hold, 1'b1);
        check("idle_in_ready", in_ready, 1'b0);
        check("idle_checksum", checksum, 0);
        check("idle_mem_addr", mem_addr, 0);
        tick();

        pld = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h78, 8'h56, 8'h34, 8'h12};
        run_load(2, 0, -1, -1);
        check("known_checksum", checksum, 32'h56077469);

        run_load(2, 5, -1, -1);

        run_load(2, 0, 6, -1);

        pld.delete();
        run_load(0, 0, -1, -1);

        fill_random(DEPTH * 4);
        run_load(DEPTH + 5, 0, -1, 100);
        check("last_addr", last_addr, DEPTH - 1);

        // reset in the middle of a load
        fill_random(8);
        start = 1'b1;
        len   = (ADDR_W+1)'(2);
        tick();
        start = 1'b0;
        send_byte(pld[0]);
        send_byte(pld[1]);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_cpu_hold", cpu_hold, 1'b1);
        check("midrst_checksum", checksum, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_data", mem_data, 0);
        tick();
        rst = 1'b1;
        tick();
        chk_exp  = '0;
        hold_exp = 1'b1;

        for (int k = 0; k < 10; k++) begin
            nl = int'($urandom_range(6, 0));
            ab = -1;
            if (nl > 0 && $urandom_range(3, 0) == 0) ab = int'($urandom_range(nl * 4 - 1, 0));
            fill_random(nl * 4);
            run_load(nl, int'($urandom_range(3, 0)), ab, -1);
        end

        check("exp_q_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
